// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte (0xED set-LEDs,
//   0xF4 enable, 0xFF reset, ...) to the keyboard over the shared PS2_CLK /
//   PS2_DAT pair. Both lines are driven open-drain through active-high
//   pull-low enables; the top level does PS2_x = x_oe ? 1'b0 : 1'bz.
//
// Ports
//   CLOCK_50    in   system clock, single clock domain
//   Resetn      in   asynchronous active-low reset
//   send_data   in   [7:0] command byte, captured when send_req is accepted
//   send_req    in   one-cycle request, accepted only while idle
//   ps2_clk_in  in   raw PS2_CLK line level (asynchronous)
//   ps2_dat_in  in   raw PS2_DAT line level (asynchronous)
//   ps2_clk_oe  out  1 = pull PS2_CLK low
//   ps2_dat_oe  out  1 = pull PS2_DAT low
//   busy        out  high from the cycle after acceptance until done/error
//   done        out  one-cycle pulse: byte sent and device ACK seen
//   error       out  one-cycle pulse: no ACK or timeout
// -----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [7:0] send_data,
  input  logic       send_req,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int ICW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Last inhibit cycle (start bit overlaps clock inhibit) and the one before it.
  localparam logic [ICW-1:0] INH_LAST  = ICW'(INHIBIT_CYCLES - 1);
  localparam logic [ICW-1:0] INH_START = ICW'(INHIBIT_CYCLES - 2);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // Odd parity bit: 1 when the byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t           state_r, state_n;
  logic [9:0]       shreg_r, shreg_n;
  logic [3:0]       bitcnt_r, bitcnt_n;
  logic [ICW-1:0]   icnt_r, icnt_n;
  logic [TCW-1:0]   tcnt_r, tcnt_n;
  logic             clk_oe_r, clk_oe_n;
  logic             dat_oe_r, dat_oe_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic             error_r, error_n;

  logic             clk_s1_r, clk_s2_r, clk_s3_r;
  logic             dat_s1_r, dat_s2_r;
  logic             fall_r;

  logic             cnt_run_s;
  logic             tmo_hit_s;

  assign ps2_clk_oe = clk_oe_r;
  assign ps2_dat_oe = dat_oe_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;

  // Two-flop synchronizers for both lines plus a registered CLK falling-edge strobe.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      clk_s1_r <= 1'b1;
      clk_s2_r <= 1'b1;
      clk_s3_r <= 1'b1;
      dat_s1_r <= 1'b1;
      dat_s2_r <= 1'b1;
      fall_r   <= 1'b0;
    end else begin
      clk_s1_r <= ps2_clk_in;
      clk_s2_r <= clk_s1_r;
      clk_s3_r <= clk_s2_r;
      dat_s1_r <= ps2_dat_in;
      dat_s2_r <= dat_s1_r;
      fall_r   <= clk_s3_r & ~clk_s2_r;
    end
  end

  // The timeout window covers everything after the clock line is released.
  assign cnt_run_s = (state_r == ST_RELEASE) || (state_r == ST_SHIFT) ||
                     (state_r == ST_ACK)     || (state_r == ST_WAIT_IDLE);
  assign tmo_hit_s = (tcnt_r == TMO_LAST);

  // Next-state and next-output logic; outputs are registered in the block below.
  always_comb begin
    state_n  = state_r;
    shreg_n  = shreg_r;
    bitcnt_n = bitcnt_r;
    icnt_n   = icnt_r;
    tcnt_n   = cnt_run_s ? (tmo_hit_s ? tcnt_r : tcnt_r + TCW'(1)) : tcnt_r;
    clk_oe_n = clk_oe_r;
    dat_oe_n = dat_oe_r;
    busy_n   = busy_r;
    done_n   = 1'b0;
    error_n  = 1'b0;

    if (cnt_run_s && tmo_hit_s) begin
      // Device stopped clocking or never finished: give the bus back.
      state_n  = ST_IDLE;
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      busy_n   = 1'b0;
      error_n  = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (send_req) begin
            shreg_n  = {1'b1, odd_parity(send_data), send_data};
            icnt_n   = '0;
            clk_oe_n = 1'b1;
            dat_oe_n = 1'b0;
            busy_n   = 1'b1;
            state_n  = ST_INHIBIT;
          end else begin
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b0;
            busy_n   = 1'b0;
          end
        end

        ST_INHIBIT: begin
          if (icnt_r == INH_LAST) begin
            // Release CLK while DAT keeps the start bit low: request-to-send.
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b1;
            tcnt_n   = '0;
            bitcnt_n = 4'd0;
            state_n  = ST_RELEASE;
          end else begin
            icnt_n = icnt_r + ICW'(1);
            if (icnt_r == INH_START) begin
              dat_oe_n = 1'b1;
            end else begin
              dat_oe_n = 1'b0;
            end
          end
        end

        ST_RELEASE: begin
          state_n = ST_SHIFT;
        end

        ST_SHIFT: begin
          if (fall_r) begin
            // Data changes while the device holds CLK low; stop bit (1) releases DAT.
            bitcnt_n = bitcnt_r + 4'd1;
            dat_oe_n = ~shreg_r[0];
            shreg_n  = {1'b1, shreg_r[9:1]};
            if (bitcnt_r == 4'd9) begin
              state_n = ST_ACK;
            end else begin
              state_n = ST_SHIFT;
            end
          end else begin
            state_n = ST_SHIFT;
          end
        end

        ST_ACK: begin
          if (fall_r) begin
            if (!dat_s2_r) begin
              state_n = ST_WAIT_IDLE;
            end else begin
              state_n  = ST_IDLE;
              clk_oe_n = 1'b0;
              dat_oe_n = 1'b0;
              busy_n   = 1'b0;
              error_n  = 1'b1;
            end
          end else begin
            state_n = ST_ACK;
          end
        end

        ST_WAIT_IDLE: begin
          if (clk_s2_r && dat_s2_r) begin
            state_n  = ST_IDLE;
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b0;
            busy_n   = 1'b0;
            done_n   = 1'b1;
          end else begin
            state_n = ST_WAIT_IDLE;
          end
        end

        default: begin
          state_n  = ST_IDLE;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          busy_n   = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_r  <= ST_IDLE;
      shreg_r  <= 10'd0;
      bitcnt_r <= 4'd0;
      icnt_r   <= '0;
      tcnt_r   <= '0;
      clk_oe_r <= 1'b0;
      dat_oe_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r  <= state_n;
      shreg_r  <= shreg_n;
      bitcnt_r <= bitcnt_n;
      icnt_r   <= icnt_n;
      tcnt_r   <= tcnt_n;
      clk_oe_r <= clk_oe_n;
      dat_oe_r <= dat_oe_n;
      busy_r   <= busy_n;
      done_r   <= done_n;
      error_r  <= error_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
//   Directed plus randomized bench for ps2_host_tx. A behavioural keyboard
//   clocks the frame at a 40-cycle period, captures what it sees on DAT, and
//   optionally ACKs. Expected frames come from a byte-level model (ones count
//   for parity, stop bit 1).
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH  = 10;
  localparam int TMO  = 3000;
  localparam int HALF = 20;

  logic       CLOCK_50;
  logic       Resetn;
  logic [7:0] send_data;
  logic       send_req;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic       error;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;

  int total = 0;
  int bad   = 0;

  int   done_cnt       = 0;
  int   err_cnt        = 0;
  int   both_cnt       = 0;
  int   busy_pulse_cnt = 0;
  int   long_pulse_cnt = 0;
  int   clk_run        = 0;
  int   last_clk_run   = 0;
  logic done_q         = 1'b0;
  logic err_q          = 1'b0;

  // Open-drain wired-AND of host and device on each line.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .Resetn    (Resetn),
    .send_data (send_data),
    .send_req  (send_req),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Pulse bookkeeping and CLK-inhibit length, sampled away from the active edge.
  always @(negedge CLOCK_50) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (error === 1'b1) err_cnt <= err_cnt + 1;
    if (done === 1'b1 && error === 1'b1) both_cnt <= both_cnt + 1;
    if ((done === 1'b1 || error === 1'b1) && busy === 1'b1) busy_pulse_cnt <= busy_pulse_cnt + 1;
    if ((done === 1'b1 && done_q) || (error === 1'b1 && err_q)) long_pulse_cnt <= long_pulse_cnt + 1;
    done_q <= (done === 1'b1);
    err_q  <= (error === 1'b1);
    if (ps2_clk_oe === 1'b1) begin
      clk_run <= clk_run + 1;
    end else begin
      if (clk_run != 0) last_clk_run <= clk_run;
      clk_run <= 0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Reference frame as the device should see it: data LSB first, odd parity, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return {1'b1, (ones % 2 == 0), d};
  endfunction

  task automatic do_send(input logic [7:0] d, input string tag);
    send_data = d;
    send_req  = 1'b1;
    cyc(1);
    send_req  = 1'b0;
    chk({tag, "_accept"}, 32'({busy, ps2_clk_oe}), 32'd3);
  endtask

  // Behavioural keyboard: waits for request-to-send, clocks 11 bits, samples DAT
  // at the end of each low phase, ACKs by pulling DAT low before the 11th fall.
  task automatic dev_xfer(input bit do_ack, input int abort_at,
                          output logic [9:0] cap, output bit seen);
    int n;
    cap  = 10'd0;
    n    = 0;
    while (!(ps2_clk_in === 1'b1 && ps2_dat_in === 1'b0 && ps2_clk_oe === 1'b0) && n < 300) begin
      cyc(1);
      n++;
    end
    seen = (n < 300);
    if (seen) begin
      for (int k = 1; k <= 11; k++) begin
        cyc(HALF);
        dev_clk = 1'b0;
        cyc(HALF);
        if (k <= 10) cap[k-1] = ps2_dat_in;
        if (abort_at == k) begin
          #2 Resetn = 1'b0;
          return;
        end
        dev_clk = 1'b1;
        if (k == 10 && do_ack) begin
          cyc(5);
          dev_dat = 1'b0;
        end
      end
      cyc(5);
      dev_dat = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input bit poke, input string tag);
    logic [9:0] cap;
    bit         seen;
    int         d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    do_send(d, tag);
    if (poke) begin
      cyc(2);
      send_data = 8'h55;
      send_req  = 1'b1;
      cyc(1);
      send_req  = 1'b0;
      send_data = d;
    end
    dev_xfer(ack, 0, cap, seen);
    chk({tag, "_req"}, 32'(seen), 32'd1);
    chk({tag, "_frame"}, 32'(cap), 32'(frame_of(d)));
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      cyc(1);
      n++;
    end
    cyc(2);
    chk({tag, "_done"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    chk({tag, "_err"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
    chk({tag, "_lines"}, 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'd0);
  endtask

  initial begin
    logic [9:0] cap;
    logic [9:0] exp10;
    bit         seen;
    int         d0, e0, n;
    logic [7:0] rd;
    bit         ra;

    // Reset state, with a request that must be ignored while Resetn is low.
    Resetn    = 1'b0;
    send_req  = 1'b0;
    send_data = 8'h00;
    cyc(2);
    send_data = 8'hAA;
    send_req  = 1'b1;
    cyc(2);
    chk("reset_outputs", 32'({ps2_clk_oe, ps2_dat_oe, busy, done, error}), 32'd0);
    send_req = 1'b0;
    Resetn   = 1'b1;
    cyc(3);
    chk("reset_req_ignored", 32'({busy, ps2_clk_oe}), 32'd0);

    // 1: 0xED with ACK, inhibit length check.
    run_frame(8'hED, 1'b1, 1'b0, "ed");
    chk("ed_inhibit_len", 32'(last_clk_run), 32'(INH));

    // 2: 0xF4 (parity 0) and 0x00 (parity 1).
    run_frame(8'hF4, 1'b1, 1'b0, "f4");
    run_frame(8'h00, 1'b1, 1'b0, "zero");

    // 3: device does not ACK.
    run_frame(8'hF4, 1'b0, 1'b0, "nack");

    // 4: device never clocks after release -> timeout.
    d0 = done_cnt;
    e0 = err_cnt;
    do_send(8'hFF, "tmo");
    n = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && n < 100) begin
      cyc(1);
      n++;
    end
    chk("tmo_release_seen", 32'(n < 100), 32'd1);
    n = 0;
    while (error !== 1'b1 && n < 4000) begin
      cyc(1);
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'(TMO));
    cyc(2);
    chk("tmo_lines", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'd0);
    chk("tmo_err", 32'(err_cnt - e0), 32'd1);
    chk("tmo_done", 32'(done_cnt - d0), 32'd0);
    run_frame(8'hFF, 1'b1, 1'b0, "ff_after_tmo");

    // 5: request while busy is ignored.
    run_frame(8'hED, 1'b1, 1'b1, "poke");
    cyc(30);
    chk("poke_stays_idle", 32'({busy, ps2_clk_oe, ps2_dat_oe}), 32'd0);

    // 6: reset in the middle of the data bits.
    d0 = done_cnt;
    e0 = err_cnt;
    do_send(8'hF4, "rst");
    dev_xfer(1'b1, 5, cap, seen);
    #1;
    chk("rst_lines", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'd0);
    exp10 = frame_of(8'hF4);
    chk("rst_partial_bits", 32'(cap[4:0]), 32'(exp10[4:0]));
    dev_clk = 1'b1;
    cyc(3);
    Resetn = 1'b1;
    cyc(3);
    chk("rst_no_pulse", 32'({done_cnt - d0, err_cnt - e0}), 32'd0);
    run_frame(8'hF4, 1'b1, 1'b0, "after_rst");

    // Randomized bytes and ACK behaviour.
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      ra = 1'($urandom_range(0, 1));
      run_frame(rd, ra, 1'b0, "rand");
    end

    chk("never_both", 32'(both_cnt), 32'd0);
    chk("busy_low_at_pulse", 32'(busy_pulse_cnt), 32'd0);
    chk("pulse_one_cycle", 32'(long_pulse_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
